if_id_fetch_queue: RTL and testbench
====================================

# if_id_fetch_queue

Decoupling queue between the fetch stage and the decode stage of the ARM pipeline. Each cycle it captures the fetch stage's {PC+4, instruction} pair into a small circular buffer and presents the oldest entry to decode through a valid/ready handshake. It raises `freeze` back to fetch when full, so fetch holds its PC register. A taken branch discards every queued entry in one cycle.

## Interface

Parameters:
- `N`, 32, datapath width of the PC and instruction words.
- `DEPTH`, 4, number of queue entries; power of two, minimum 2.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `pc_in`  in  N  PC+4 produced by fetch.
- `instr_in`  in  N  fetched instruction word.
- `in_valid`  in  1  fetch presents a new pair this cycle.
- `freeze`  out  1  queue full; fetch must hold its PC and keep the current pair stable.
- `flush`  in  1  branch taken; discard all entries.
- `pc_out`  out  N  PC+4 of the head entry.
- `instr_out`  out  N  instruction of the head entry.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  decode accepts the head this cycle; low means a hazard stall.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation

- Storage is a circular array with write pointer `wp`, read pointer `rp`, both log2(DEPTH) bits, and an occupancy counter `count`.
- Push: `in_valid && !freeze && !flush`. The pair is written at `wp`, then `wp` increments modulo DEPTH.
- Pop: `out_valid && out_ready && !flush`. `rp` increments modulo DEPTH.
- Counter update:
  - push and pop together leaves `count` unchanged;
  - push only increments it;
  - pop only decrements it.
- `freeze = (count == DEPTH)`. It is decoded from registered state only and has no combinational path from `out_ready`. A pop while full does not admit a push in the same cycle.
- `out_valid = (count != 0)`.
- Head data: `pc_out`/`instr_out` read combinationally from `rp` when `out_valid`. When empty they are forced to 0, which is the NOP encoding.
- Flush priority: flush overrides push and pop in the same cycle. Next state is `wp = rp = 0`, `count = 0`.
- Pointers wrap silently; because `count` distinguishes full from empty, no extra wrap bit is needed.
- `in_valid` while `freeze` is ignored. Fetch re-presents the same pair, since it is frozen.

## Timing

- Reset values, holding while `rst == 0` at an edge:
  - `wp`, `rp` = 0 and `count` = 0;
  - `out_valid` = 0 and `freeze` = 0;
  - `pc_out` = 0 and `instr_out` = 0;
  - storage contents don't-care.
- Reset mid-operation behaves identically to flush, and also takes priority over flush.
- Latency is 1 cycle: a pair pushed at edge k appears on `pc_out`/`instr_out` with `out_valid` high after edge k, when the queue was empty.
- No bypass: an empty queue never presents `pc_in` on the output in the same cycle.
- Throughput: one push and one pop per cycle in steady state. This gives full bandwidth when `DEPTH` ≥ 2 and decode never stalls.
- Handshake stability: while `out_valid && !out_ready`, the head outputs stay constant until popped or flushed.
- `freeze` rises the cycle after the push that fills the queue. It falls the cycle after the first pop from full.

## Structure

- Shared package `arm_pkg`:
  - `INSTR_W = 32`;
  - `NOP_INSTR = 32'h0`;
  - a packed typedef `fetch_pair_t` {pc, instr} reused by the later ID-stage register.
- One sub-module, `fetch_queue_mem`: a DEPTH×2N register array with one write port and one asynchronous read port, with no reset.
- Pointer, counter, and control logic live in the top module.

## Test plan

- **Reset:** hold `rst=0` for 2 cycles with `in_valid=1` → `count=0`, `out_valid=0`, `freeze=0`, outputs 0x0.
- **Fill:** push 4 pairs (pc 0x4, 0x8, 0xC, 0x10) with `out_ready=0` → `count=4`, `freeze=1` after the 4th edge. A 5th `in_valid` with pc 0x14 is not stored; the head still reads pc 0x4.
- **Streaming:** `in_valid=1` and `out_ready=1` for 10 cycles on sequential pcs → decode sees 0x4, 0x8, … in order, `count` stays 1, and `freeze` is never asserted.
- **Wrap-around:** 6 pushes interleaved with 6 pops at `DEPTH=4` → order is preserved across the `wp`/`rp` wrap, and `count` returns to 0.
- **Flush with push and pop:** with 3 entries queued, assert `flush`, `in_valid`, and `out_ready` together → next cycle `count=0`, `out_valid=0`, and the new pair is discarded.
- **Stall stability:** with the head at pc 0x20, hold `out_ready=0` for 5 cycles while pushing → `pc_out` stays 0x20 and `instr_out` is unchanged until `out_ready=1`.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline front end.
//   INSTR_W      : architectural instruction / PC word width
//   NOP_INSTR    : encoding presented to decode when no instruction is available
//   fetch_pair_t : {pc, instr} pair carried from fetch towards the ID-stage register
package arm_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pair_t;

endpackage : arm_pkg

// File: rtl/fetch_queue_mem.sv
// Storage array of the IF/ID fetch queue: DEPTH entries of W bits, one
// synchronous write port and one asynchronous read port. No reset; the
// control logic in the parent never reads an entry it has not written.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fetch_queue_mem
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Entry write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fetch_queue_mem

// File: rtl/if_id_fetch_queue.sv
// Decoupling queue between fetch and decode. Captures {PC+4, instr} pairs
// from fetch into a circular buffer and offers the oldest entry to decode
// through a valid/ready handshake. Full raises freeze back to fetch; flush
// (taken branch) empties the queue in one cycle.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   pc_in, instr_in    : pair presented by fetch
//   in_valid           : fetch presents a pair this cycle
//   freeze             : queue full, fetch must hold
//   flush              : discard all entries
//   pc_out, instr_out  : head entry (0 / NOP when empty)
//   out_valid          : head entry present
//   out_ready          : decode accepts the head this cycle
//   count              : current occupancy
module if_id_fetch_queue
  import arm_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               pc_in,
  input  logic [N-1:0]               instr_in,
  input  logic                       in_valid,
  output logic                       freeze,
  input  logic                       flush,
  output logic [N-1:0]               pc_out,
  output logic [N-1:0]               instr_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s;
  logic             pop_s;
  logic [2*N-1:0]   rdata_s;

  // Status decoded from registered occupancy only, so freeze never sees out_ready.
  assign freeze    = (count_q == CNT_W'(DEPTH));
  assign out_valid = (count_q != {CNT_W{1'b0}});
  assign count     = count_q;

  // A pop while full does not free a slot for a same-cycle push because
  // push is gated by the registered freeze.
  assign push_s = in_valid && !freeze && !flush;
  assign pop_s  = out_valid && out_ready && !flush;

  // Next-state for pointers and occupancy; flush empties the queue.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = {PTR_W{1'b0}};
      rp_d    = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push_s) begin
        wp_d = wp_q + PTR_W'(1);
      end else begin
        wp_d = wp_q;
      end
      if (pop_s) begin
        rp_d = rp_q + PTR_W'(1);
      end else begin
        rp_d = rp_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= {PTR_W{1'b0}};
      rp_q    <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (2*N)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wp_q),
    .wdata ({pc_in, instr_in}),
    .raddr (rp_q),
    .rdata (rdata_s)
  );

  // Head presentation; an empty queue shows PC 0 and a NOP to decode.
  always_comb begin
    pc_out    = {N{1'b0}};
    instr_out = N'(NOP_INSTR);
    if (out_valid) begin
      pc_out    = rdata_s[2*N-1:N];
      instr_out = rdata_s[N-1:0];
    end else begin
      pc_out    = {N{1'b0}};
      instr_out = N'(NOP_INSTR);
    end
  end

endmodule : if_id_fetch_queue

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue (N=32, DEPTH=4).
module tb_if_id_fetch_queue;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  pc_in, instr_in;
  logic          in_valid, flush, out_ready;
  logic          freeze, out_valid;
  logic [N-1:0]  pc_out, instr_out;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: an ordered list of {pc, instr} entries.
  logic [2*N-1:0] mq[$];

  if_id_fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
    .in_valid(in_valid), .freeze(freeze), .flush(flush),
    .pc_out(pc_out), .instr_out(instr_out), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] ins(input logic [N-1:0] pc);
    return 32'hE3A0_0000 ^ (pc << 4);
  endfunction

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic chk_model(input string tag);
    logic [2*N-1:0] h;
    h = (mq.size() != 0) ? mq[0] : {2*N{1'b0}};
    chk({tag, ".count"},  N'(count),     N'(mq.size()));
    chk({tag, ".valid"},  N'(out_valid), N'(mq.size() != 0));
    chk({tag, ".freeze"}, N'(freeze),    N'(mq.size() == DEPTH));
    chk({tag, ".pc"},     pc_out,        h[2*N-1:N]);
    chk({tag, ".instr"},  instr_out,     h[N-1:0]);
  endtask

  // Drive one cycle, advance the reference by the queue rules, sample #1 after the edge.
  task automatic step(input logic r, input logic iv, input logic fl,
                      input logic ordy, input logic [N-1:0] pc);
    bit full, pop, push;
    rst = r; in_valid = iv; flush = fl; out_ready = ordy;
    pc_in = pc; instr_in = ins(pc);
    @(posedge clk);
    if (!r || fl) begin
      mq.delete();
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && ordy;
      push = iv && !full;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({pc, ins(pc)});
    end
    #1;
  endtask

  typedef struct {
    logic          r, iv, fl, ordy;
    logic [N-1:0]  pc;
    int            e_cnt;
    logic          e_valid, e_freeze;
    logic [N-1:0]  e_pc;
  } vec_t;

  vec_t vt[11];

  initial begin
    // rst iv fl rdy pc     cnt v f head_pc
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h04, 0, 1'b0, 1'b0, 32'h00};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h04, 0, 1'b0, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h04, 1, 1'b1, 1'b0, 32'h04};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h08, 2, 1'b1, 1'b0, 32'h04};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 3, 1'b1, 1'b0, 32'h04};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 4, 1'b1, 1'b1, 32'h04};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h14, 4, 1'b1, 1'b1, 32'h04};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 3, 1'b1, 1'b0, 32'h08};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h14, 4, 1'b1, 1'b1, 32'h08};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 0, 1'b0, 1'b0, 32'h00};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h1C, 0, 1'b0, 1'b0, 32'h00};

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_in = '0; instr_in = '0;

    // Table-driven: reset, fill, frozen push ignored, pop-from-full, flush.
    for (int i = 0; i < 11; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vt[i].r, vt[i].iv, vt[i].fl, vt[i].ordy, vt[i].pc);
      chk({t, ".count"},  N'(count),     N'(vt[i].e_cnt));
      chk({t, ".valid"},  N'(out_valid), N'(vt[i].e_valid));
      chk({t, ".freeze"}, N'(freeze),    N'(vt[i].e_freeze));
      chk({t, ".pc"},     pc_out,        vt[i].e_pc);
      chk({t, ".instr"},  instr_out,     vt[i].e_valid ? ins(vt[i].e_pc) : 32'h0);
    end

    // No bypass: an empty queue shows nothing while fetch presents a pair.
    in_valid = 1'b1; pc_in = 32'h04; instr_in = ins(32'h04); #1;
    chk("nobypass.valid", N'(out_valid), 32'h0);
    chk("nobypass.pc",    pc_out,        32'h0);

    // Streaming: ten sequential pcs, decode always ready.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'(4 * (i + 1)));
      chk("stream.pc", pc_out, 32'(4 * (i + 1)));
      chk("stream.count", N'(count), 32'h1);
      chk_model("stream");
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_model("stream_drain");

    // Wrap-around: six pushes interleaved with six pops.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i));
      chk_model("wrap_push");
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      chk_model("wrap_pop");
    end
    chk("wrap.count_end", N'(count), 32'h0);

    // Flush together with push and pop, three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * i));
    chk_model("preflush");
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
    chk("flush.count", N'(count), 32'h0);
    chk("flush.valid", N'(out_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("flush.discard", N'(count), 32'h0);

    // Stall stability: head at 0x20 while decode stalls and fetch keeps pushing.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h24 + 32'(4 * i));
      chk("stall.pc",    pc_out,    32'h20);
      chk("stall.instr", instr_out, ins(32'h20));
      chk_model("stall");
    end
    // Full: raising out_ready must not drop freeze combinationally.
    out_ready = 1'b1; #1;
    chk("freeze_no_comb", N'(freeze), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h30);
    chk("stall.release_pc", pc_out, 32'h24);
    chk_model("release");

    // Mid-operation reset, also asserted with flush.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    chk_model("midreset");

    // Randomised traffic against the reference queue.
    for (int i = 0; i < 600; i++) begin
      logic r, iv, fl, rd;
      r  = ($urandom_range(0, 49) != 0);
      iv = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      rd = ($urandom_range(0, 2) != 0);
      step(r, iv, fl, rd, $urandom);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_if_id_fetch_queue
